// File: rtl/mfcc_pkg.sv
// Shared types and defaults for the MFCC frame packer and its beat buffer.
package mfcc_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_COEF_NUM = 13;
    localparam int DEF_FCNT_W   = 16;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_SUM = 1'b1
    } state_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic                  sof;
        logic                  eof;
    } beat_t;

    // Pointer increment for the 3-entry ring (0,1,2,0,...).
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/mfcc_frame_packer_if.sv
// Framed valid/ready beat stream from the packer to the transport stage.
interface mfcc_frame_packer_if #(
    parameter int DATA_W = mfcc_pkg::DEF_DATA_W
);
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_sof;
    logic              m_eof;

    modport master (output m_valid, output m_data, output m_sof, output m_eof, input m_ready);
    modport slave  (input m_valid, input m_data, input m_sof, input m_eof, output m_ready);
endinterface

// File: rtl/mfcc_beat_buf.sv
// Three-entry synchronous beat FIFO; head entry drives the output stream directly.
module mfcc_beat_buf
    import mfcc_pkg::*;
#(
    parameter type T = beat_t
)(
    input  logic       clk,
    input  logic       rstn,
    input  logic       flush,
    input  logic       push,
    input  T           push_beat,
    input  logic       pop,
    output T           head_beat,
    output logic [1:0] occ
);

    T           mem_reg [3];
    logic [1:0] head_reg;
    logic [1:0] tail_reg;
    logic [1:0] occ_reg;
    logic [2:0] wr_en;
    logic       push_ok;
    logic       pop_ok;

    assign pop_ok  = pop && (occ_reg != 2'd0);
    assign push_ok = push && (occ_reg != 2'd3);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_wr
            assign wr_en[gi] = push_ok && !flush && (tail_reg == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 3; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (wr_en[i]) begin
                    mem_reg[i] <= push_beat;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_reg <= 2'd0;
            tail_reg <= 2'd0;
            occ_reg  <= 2'd0;
        end else if (flush) begin
            head_reg <= 2'd0;
            tail_reg <= 2'd0;
            occ_reg  <= 2'd0;
        end else begin
            if (push_ok) begin
                tail_reg <= ptr_inc(tail_reg);
            end
            if (pop_ok) begin
                head_reg <= ptr_inc(head_reg);
            end
            occ_reg <= occ_reg + 2'(push_ok) - 2'(pop_ok);
        end
    end

    assign head_beat = mem_reg[head_reg];
    assign occ       = occ_reg;

endmodule

// File: rtl/mfcc_frame_packer.sv
// Pops MFCC coefficients from the FIFO and emits framed sof/eof beats at 1 word/clk.
// Define MFCC_FRAME_SUM_EN to append a modulo-2^DATA_W checksum beat to every frame.
module mfcc_frame_packer
    import mfcc_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int COEF_NUM = DEF_COEF_NUM,
    parameter int FCNT_W   = DEF_FCNT_W
)(
    input  logic                clk,
    input  logic                rstn,
    input  logic                fifo_empty,
    output logic                fifo_rden,
    input  logic [DATA_W-1:0]   fifo_data,
    input  logic                flush,
    mfcc_frame_packer_if.master m,
    output logic [FCNT_W-1:0]   frame_cnt,
    output logic                busy
);

    localparam int IDX_W = (COEF_NUM > 1) ? $clog2(COEF_NUM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COEF_NUM - 1);
`ifdef MFCC_FRAME_SUM_EN
    localparam bit SUM_EN = 1'b1;
`else
    localparam bit SUM_EN = 1'b0;
`endif

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sof;
        logic              eof;
    } beat_w_t;

    logic [IDX_W-1:0]  idx_reg;
    logic [IDX_W-1:0]  idx_next;
    logic              inflight_reg;
    logic              pend_sof_reg;
    logic              pend_eof_reg;
    logic              active_reg;
    logic [FCNT_W-1:0] frame_cnt_reg;
    logic [1:0]        occ;
    beat_w_t           head_beat;
    beat_w_t           push_beat;
    logic              push;
    logic              pop;
    logic              run_ok;
    logic              room;
    logic              last_word;
    logic              busy_sum;

    // Reserve a slot for the word already in flight so a landing never overflows.
    assign room      = ({1'b0, occ} + {2'b00, inflight_reg}) < 3'd3;
    assign last_word = (idx_reg == LAST_IDX);
    // active_reg keeps the pop strobe low throughout reset and its first release cycle.
    assign fifo_rden = active_reg && run_ok && room && !fifo_empty && !flush;

`ifdef MFCC_FRAME_SUM_EN
    state_t            state_reg;
    state_t            state_next;
    logic [DATA_W-1:0] sum_reg;
    logic              sum_push;

    assign run_ok   = (state_reg == ST_RUN);
    assign sum_push = (state_reg == ST_SUM) && !inflight_reg && (occ != 2'd3) && !flush;
    assign push     = !flush && (inflight_reg || sum_push);
    assign busy_sum = (state_reg == ST_SUM);

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = ST_RUN;
        end else begin
            case (state_reg)
                ST_RUN:  if (fifo_rden && last_word) state_next = ST_SUM;
                ST_SUM:  if (sum_push) state_next = ST_RUN;
                default: state_next = ST_RUN;
            endcase
        end
    end

    always_comb begin
        push_beat = '{data: fifo_data, sof: pend_sof_reg, eof: pend_eof_reg};
        if (sum_push) begin
            push_beat = '{data: sum_reg, sof: 1'b0, eof: 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= ST_RUN;
            sum_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (flush || sum_push) begin
                sum_reg <= '0;
            end else if (inflight_reg) begin
                sum_reg <= sum_reg + fifo_data;
            end
        end
    end
`else
    assign run_ok    = 1'b1;
    assign push      = inflight_reg && !flush;
    assign busy_sum  = 1'b0;
    assign push_beat = '{data: fifo_data, sof: pend_sof_reg, eof: pend_eof_reg};
`endif

    always_comb begin
        idx_next = idx_reg;
        if (flush) begin
            idx_next = '0;
        end else if (fifo_rden) begin
            idx_next = last_word ? '0 : idx_reg + IDX_W'(1);
        end
    end

    // Frame flags are fixed when the word is popped, since idx has moved on by landing time.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_reg       <= '0;
            inflight_reg  <= 1'b0;
            pend_sof_reg  <= 1'b0;
            pend_eof_reg  <= 1'b0;
            active_reg    <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            active_reg   <= 1'b1;
            inflight_reg <= fifo_rden;
            idx_reg      <= idx_next;
            if (fifo_rden) begin
                pend_sof_reg <= (idx_reg == '0);
                pend_eof_reg <= last_word && !SUM_EN;
            end
            if (pop && head_beat.eof) begin
                frame_cnt_reg <= frame_cnt_reg + FCNT_W'(1);
            end
        end
    end

    mfcc_beat_buf #(
        .T (beat_w_t)
    ) u_buf (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .push      (push),
        .push_beat (push_beat),
        .pop       (pop),
        .head_beat (head_beat),
        .occ       (occ)
    );

    assign pop       = m.m_valid && m.m_ready;
    assign m.m_valid = (occ != 2'd0);
    assign m.m_data  = head_beat.data;
    assign m.m_sof   = head_beat.sof;
    assign m.m_eof   = head_beat.eof;
    assign frame_cnt = frame_cnt_reg;
    assign busy      = (idx_reg != '0) || (occ != 2'd0) || inflight_reg || busy_sum;

endmodule
